// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one variable-latency single-port RAM between two requesters,
// with a SERVE stall timeout and sticky protocol/timeout error flag.
module ram_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NREQ-1:0] req_ren,
  input  logic [NREQ-1:0] req_wen,
  input  logic [31:0]     req_addr0,
  input  logic [31:0]     req_addr1,
  input  logic [31:0]     req_store0,
  input  logic [31:0]     req_store1,
  output logic [31:0]     req_load,
  output logic [NREQ-1:0] req_wait,
  output logic            ram_ren,
  output logic            ram_wen,
  output logic [31:0]     ram_addr,
  output logic [31:0]     ram_store,
  input  logic [31:0]     ram_load,
  input  logic [1:0]      ram_state,
  output logic            owner,
  output logic            err
);

  typedef enum logic {ST_IDLE, ST_SERVE} state_t;
  typedef enum logic [1:0] {
    RS_FREE   = 2'd0,
    RS_BUSY   = 2'd1,
    RS_ACCESS = 2'd2,
    RS_ERROR  = 2'd3
  } ramstate_t;

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  state_t          r_state, w_state_nxt;
  logic            r_owner, w_owner_nxt;
  logic            r_last,  w_last_nxt;
  logic [7:0]      r_tcnt,  w_tcnt_nxt;
  logic            r_err,   w_err_nxt;

  ramstate_t       w_rs;
  logic [NREQ-1:0] w_active;
  logic [NREQ-1:0] w_illegal;
  logic [NREQ-1:0] w_any;

  assign w_rs      = ramstate_t'(ram_state);
  assign w_active  = req_ren ^ req_wen;
  assign w_illegal = req_ren & req_wen;
  assign w_any     = req_ren | req_wen;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_tcnt_nxt  = r_tcnt;
    w_err_nxt   = r_err | (|w_illegal);
    case (r_state)
      ST_IDLE: begin
        if (|w_active) begin
          // On a tie the requester that was not served last wins
          w_owner_nxt = (&w_active) ? ~r_last : w_active[1];
          w_state_nxt = ST_SERVE;
          w_tcnt_nxt  = '0;
        end
      end
      ST_SERVE: begin
        if (w_rs == RS_ERROR) begin
          w_err_nxt = 1'b1;
        end
        if (w_rs == RS_ACCESS) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
        end else if (!w_active[r_owner]) begin
          w_state_nxt = ST_IDLE;
        end else if (r_tcnt == TCNT_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
        end else begin
          w_tcnt_nxt  = r_tcnt + 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_wait  = w_any;
    req_load  = '0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    if (r_state == ST_SERVE) begin
      // RAM follows the owner's live inputs so mid-transfer changes pass straight through
      ram_ren   = req_ren[r_owner];
      ram_wen   = req_wen[r_owner];
      ram_addr  = r_owner ? req_addr1  : req_addr0;
      ram_store = r_owner ? req_store1 : req_store0;
      req_load  = ram_load;
      if (w_rs == RS_ACCESS && !w_illegal[r_owner]) begin
        req_wait[r_owner] = 1'b0;
      end
    end
  end

  assign owner = r_owner;
  assign err   = r_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: RAM model answers ACCESS on the 3rd consecutive
// cycle of a stable request (or stays BUSY when stuck).
module tb_ram_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  req_ren, req_wen;
  logic [31:0] req_addr0, req_addr1, req_store0, req_store1;
  logic [31:0] req_load;
  logic [1:0]  req_wait;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store, ram_load;
  logic [1:0]  ram_state;
  logic        owner, err;

  int vectors = 0;
  int miscompares = 0;

  ram_arbiter #(.NREQ(2), .TIMEOUT(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_store0(req_store0), .req_store1(req_store1),
    .req_load(req_load), .req_wait(req_wait),
    .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_state(ram_state),
    .owner(owner), .err(err)
  );

  always #5 CLK = ~CLK;

  // RAM model: mem[i] preloaded with 0xA500_0000 | i
  logic [31:0] mem [0:255];
  logic [31:0] prev_addr = '0;
  logic        prev_wen = 1'b0;
  int unsigned cnt = 0;
  logic        stuck = 1'b0;
  logic        m_valid, m_same;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
  end

  assign m_valid  = ram_ren | ram_wen;
  assign m_same   = (ram_addr == prev_addr) && (ram_wen == prev_wen);
  assign ram_load = mem[ram_addr[7:0]];

  always_comb begin
    ram_state = 2'd0;
    if (m_valid) ram_state = (!stuck && cnt >= 2 && m_same) ? 2'd2 : 2'd1;
  end

  always @(posedge CLK) begin
    if (ram_state == 2'd2) begin
      if (ram_wen) mem[ram_addr[7:0]] <= ram_store;
      cnt <= 0;
    end else if (m_valid) begin
      cnt <= (cnt != 0 && m_same) ? cnt + 1 : 1;
    end else begin
      cnt <= 0;
    end
    prev_addr <= ram_addr;
    prev_wen  <= ram_wen;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; req_ren = '0; req_wen = '0;
    req_addr0 = '0; req_addr1 = '0; req_store0 = '0; req_store1 = '0;
    smp();
    chk("rst_owner", owner, 0);
    chk("rst_err", err, 0);
    chk("rst_ram_ren", ram_ren, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_wait", req_wait, 0);
    chk("rst_load", req_load, 0);
    tick(); nRST = 1'b1;

    // 1: single read, ACCESS in the 3rd SERVE cycle
    tick(); req_ren = 2'b01; req_addr0 = 32'h40;
    smp(); chk("t1_c0_wait", req_wait, 2'b01); chk("t1_c0_ram_ren", ram_ren, 0);
    tick(); smp(); chk("t1_c1_ram_ren", ram_ren, 1); chk("t1_c1_addr", ram_addr, 32'h40);
    chk("t1_c1_owner", owner, 0);
    tick(); smp(); chk("t1_c2_wait", req_wait, 2'b01);
    tick(); smp(); chk("t1_c3_wait", req_wait, 2'b00); chk("t1_c3_load", req_load, 32'hA500_0040);
    tick(); req_ren = 2'b00;
    smp(); chk("t1_c4_ram_ren", ram_ren, 0); chk("t1_c4_load", req_load, 0);

    tick(); nRST = 1'b0; #2; nRST = 1'b1;

    // 2: simultaneous reads, req0 first then req1 after one IDLE cycle
    tick(); req_ren = 2'b11; req_addr0 = 32'h10; req_addr1 = 32'h20;
    smp(); chk("t2_c0_wait", req_wait, 2'b11);
    tick(); smp(); chk("t2_c1_owner", owner, 0); chk("t2_c1_addr", ram_addr, 32'h10);
    chk("t2_c1_wait", req_wait, 2'b11);
    tick(); smp(); chk("t2_c2_wait", req_wait, 2'b11);
    tick(); smp(); chk("t2_c3_wait", req_wait, 2'b10); chk("t2_c3_load", req_load, 32'hA500_0010);
    tick(); req_ren = 2'b10;
    smp(); chk("t2_c4_ram_ren", ram_ren, 0); chk("t2_c4_wait", req_wait, 2'b10);
    tick(); smp(); chk("t2_c5_owner", owner, 1); chk("t2_c5_addr", ram_addr, 32'h20);
    chk("t2_c5_ram_ren", ram_ren, 1);
    tick(); tick(); smp(); chk("t2_c7_wait", req_wait, 2'b00);
    chk("t2_c7_load", req_load, 32'hA500_0020);
    tick(); req_ren = 2'b00;

    // 3: req1 write held, req0 read held: grants alternate 0,1,0,1
    tick(); req_ren = 2'b01; req_wen = 2'b10; req_addr0 = 32'h44; req_addr1 = 32'h80;
    req_store1 = 32'hDEAD_BEEF;
    for (int g = 0; g < 4; g++) begin
      tick(); smp();
      chk("t3_owner", owner, (g % 2 == 1) ? 1 : 0);
      chk("t3_addr", ram_addr, (g % 2 == 1) ? 32'h80 : 32'h44);
      tick(); tick(); smp();
      chk("t3_access_wait", req_wait, (g % 2 == 1) ? 2'b01 : 2'b10);
      tick(); smp();
      chk("t3_idle_ram_wen", ram_wen, 0);
      if (g == 0) chk("t3_mem_before", mem[8'h80], 32'hA500_0080);
      if (g == 1) chk("t3_mem_after", mem[8'h80], 32'hDEAD_BEEF);
    end
    req_ren = 2'b00; req_wen = 2'b00;

    // 4: owner drops request mid-SERVE; last is not updated
    tick(); req_ren = 2'b01; req_addr0 = 32'h48;
    tick(); smp(); chk("t4_c1_owner", owner, 0); chk("t4_c1_ram_ren", ram_ren, 1);
    tick(); req_ren = 2'b00;
    smp(); chk("t4_c2_ram_ren", ram_ren, 0);
    tick(); req_ren = 2'b11; req_addr1 = 32'h28;
    smp(); chk("t4_c3_ram_ren", ram_ren, 0); chk("t4_c3_wait", req_wait, 2'b11);
    tick(); smp(); chk("t4_c4_owner", owner, 0); chk("t4_c4_addr", ram_addr, 32'h48);
    tick(); req_ren = 2'b00;
    tick();

    // 5: RAM stuck BUSY -> timeout after 16 SERVE cycles, then req1 granted
    stuck = 1'b1;
    tick(); req_ren = 2'b11; req_addr0 = 32'h50; req_addr1 = 32'h24;
    tick();
    repeat (15) tick();
    smp(); chk("t5_c16_err", err, 0); chk("t5_c16_wait", req_wait, 2'b11);
    chk("t5_c16_ram_ren", ram_ren, 1); chk("t5_c16_owner", owner, 0);
    tick(); smp(); chk("t5_c17_err", err, 1); chk("t5_c17_ram_ren", ram_ren, 0);
    tick(); smp(); chk("t5_c18_owner", owner, 1); chk("t5_c18_addr", ram_addr, 32'h24);
    req_ren = 2'b00; stuck = 1'b0;

    // 6: illegal ren&wen never granted, sets err; async reset mid-SERVE clears everything
    tick(); nRST = 1'b0; #1;
    chk("t6_rst_err", err, 0);
    nRST = 1'b1;
    tick(); req_ren = 2'b01; req_wen = 2'b01;
    smp(); chk("t6_c0_wait", req_wait, 2'b01); chk("t6_c0_ram_ren", ram_ren, 0);
    chk("t6_c0_err", err, 0);
    tick(); smp(); chk("t6_c1_err", err, 1); chk("t6_c1_ram_ren", ram_ren, 0);
    chk("t6_c1_ram_wen", ram_wen, 0);
    tick(); req_ren = 2'b11; req_addr1 = 32'h30;
    smp(); chk("t6_c2_ram_ren", ram_ren, 0);
    tick(); smp(); chk("t6_c3_owner", owner, 1); chk("t6_c3_ram_ren", ram_ren, 1);
    chk("t6_c3_ram_wen", ram_wen, 0); chk("t6_c3_addr", ram_addr, 32'h30);
    chk("t6_c3_wait", req_wait, 2'b11); chk("t6_c3_err", err, 1);
    #1; nRST = 1'b0; #1;
    chk("t6_async_err", err, 0); chk("t6_async_owner", owner, 0);
    chk("t6_async_ram_ren", ram_ren, 0); chk("t6_async_ram_wen", ram_wen, 0);
    req_ren = 2'b00; req_wen = 2'b00;
    tick(); nRST = 1'b1;
    tick(); smp(); chk("t6_end_ram_ren", ram_ren, 0); chk("t6_end_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
